pll_reset_sequencer: RTL and testbench
======================================

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 SHALL have parameter RST_PULSE_CYCLES, default 16: number of cycles pll_rst is held high per reset attempt (min 1).
REQ-002 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before release (min 1).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 74250 (1 ms at 74.25 MHz): lock wait limit per attempt (min 2).
REQ-004 SHALL have port clk_74a  input  1  free-running 74.25 MHz reference clock; the only clock.
REQ-005 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port pll_locked  input  1  PLL lock, asynchronous to clk_74a.
REQ-007 SHALL have port relock_req  input  1  single-cycle request to re-run the reset sequence.
REQ-008 SHALL have port pll_rst  output  1  drives PLL rst, active-high.
REQ-009 SHALL have port core_reset_n  output  1  active-low reset for downstream PLL-clocked logic.
REQ-010 SHALL have port pll_ready  output  1  high only in RUN.
REQ-011 SHALL have port lock_lost  output  1  sticky: lock dropped while in RUN.
REQ-012 SHALL have port retry_count  output  4  saturating count of lock timeouts.
REQ-013 SHALL have port state  output  2  FSM state: ASSERT=0, WAIT=1, STABLE=2, RUN=3.

Function
REQ-014 SHALL pass pll_locked through a 2-flop synchronizer to form locked_s; the FSM SHALL use only locked_s.
REQ-015 SHALL use one shared counter, wide enough for max(RST_PULSE_CYCLES, LOCK_STABLE_CYCLES, TIMEOUT_CYCLES), cleared on every state transition.
REQ-016 SHALL drive all outputs from flops, Moore-style: pll_rst=1 iff state==ASSERT; pll_ready=1 and core_reset_n=1 iff state==RUN.
REQ-017 ASSERT: SHALL stay exactly RST_PULSE_CYCLES cycles (counter 0..N-1), then go to WAIT.
REQ-018 WAIT: SHALL go to STABLE on the first cycle locked_s=1; if the counter reaches TIMEOUT_CYCLES-1 with locked_s=0, SHALL go to ASSERT and increment retry_count, saturating at 15.
REQ-019 STABLE: SHALL go to RUN after LOCK_STABLE_CYCLES consecutive cycles of locked_s=1; on locked_s=0 SHALL return to WAIT with the counter cleared and retry_count unchanged.
REQ-020 RUN: on locked_s=0 SHALL go to ASSERT and set lock_lost=1; core_reset_n SHALL read 0 from the next cycle.
REQ-021 relock_req=1 in WAIT, STABLE or RUN SHALL force ASSERT on the next cycle, with priority over lock, timeout and stability transitions; it SHALL not set lock_lost or change retry_count.
REQ-022 relock_req=1 in ASSERT SHALL restart the pulse count at 0 (pulse extended, not truncated).
REQ-023 Simultaneous relock_req and lock loss in RUN SHALL go to ASSERT and set lock_lost=1.
REQ-024 A timeout and a locked_s rise in the same WAIT cycle SHALL resolve as lock (go to STABLE, no retry increment).
REQ-025 lock_lost and retry_count SHALL be cleared only by reset_n.

Reset
REQ-026 reset_n=0 at a clock edge SHALL set state=ASSERT, counter=0, synchronizer flops=0, pll_rst=1, core_reset_n=0, pll_ready=0, lock_lost=0, retry_count=0.
REQ-027 Reset mid-operation (any state) SHALL abort immediately to the REQ-026 values; the sequence restarts with a full RST_PULSE_CYCLES pulse after reset_n returns high.

Verification (RST_PULSE_CYCLES=4, LOCK_STABLE_CYCLES=8, TIMEOUT_CYCLES=32)
REQ-028 Nominal: release reset with pll_locked=1 from time 0 -> pll_rst high 4 cycles after release; STABLE entered 1 cycle after WAIT (locked_s already 1); RUN after 8 further cycles; core_reset_n=1, pll_ready=1, retry_count=0.
REQ-029 Timeout: pll_locked=0 for 3 attempts, then 1 -> three ASSERT pulses 36 cycles apart (4+32); retry_count=3; RUN reached.
REQ-030 Glitch: in STABLE, drop pll_locked for 1 cycle at stable count 5 -> returns to WAIT; RUN requires a fresh 8 consecutive cycles; retry_count unchanged.
REQ-031 Lock loss: in RUN, drop pll_locked -> ASSERT 2 synchronizer cycles later plus 1; lock_lost=1 and core_reset_n=0; re-lock -> RUN with lock_lost still 1.
REQ-032 Relock/reset: relock_req pulse in RUN -> ASSERT next cycle with lock_lost=0; reset_n low during STABLE -> all outputs at REQ-026 values on the next edge.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses PLL reset, waits for a stable synchronized lock,
// then releases the downstream core reset. Retries on lock timeout.
module pll_reset_sequencer #(
  parameter int RST_PULSE_CYCLES   = 16,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int TIMEOUT_CYCLES     = 74250
) (
  input  logic       clk_74a,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       core_reset_n,
  output logic       pll_ready,
  output logic       lock_lost,
  output logic [3:0] retry_count,
  output logic [1:0] state
);

  localparam int MAX_AB = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ? RST_PULSE_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_C  = (MAX_AB > TIMEOUT_CYCLES) ? MAX_AB : TIMEOUT_CYCLES;
  localparam int CW     = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] PULSE_LAST  = CW'(RST_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST     = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_ASSERT = 2'd0,
    S_WAIT   = 2'd1,
    S_STABLE = 2'd2,
    S_RUN    = 2'd3
  } state_t;

  state_t        cur, nxt;
  logic [CW-1:0] cnt;
  logic          sync1, locked_s;
  logic          clr, retry_inc, lost_set;

  // Ordering inside each state encodes the priorities: relock beats
  // lock/timeout/stability, lock beats a coincident timeout, and lock loss
  // in RUN beats relock so lock_lost is still recorded.
  always_comb begin
    nxt       = cur;
    clr       = 1'b0;
    retry_inc = 1'b0;
    lost_set  = 1'b0;
    case (cur)
      S_ASSERT: begin
        if (relock_req)             clr = 1'b1;
        else if (cnt == PULSE_LAST) nxt = S_WAIT;
      end
      S_WAIT: begin
        if (relock_req)          nxt = S_ASSERT;
        else if (locked_s)       nxt = S_STABLE;
        else if (cnt == TO_LAST) begin
          nxt       = S_ASSERT;
          retry_inc = 1'b1;
        end
      end
      S_STABLE: begin
        if (relock_req)              nxt = S_ASSERT;
        else if (!locked_s)          nxt = S_WAIT;
        else if (cnt == STABLE_LAST) nxt = S_RUN;
      end
      S_RUN: begin
        if (!locked_s) begin
          nxt      = S_ASSERT;
          lost_set = 1'b1;
        end else if (relock_req) begin
          nxt = S_ASSERT;
        end
      end
      default: nxt = S_ASSERT;
    endcase
    if (nxt != cur) clr = 1'b1;
  end

  always_ff @(posedge clk_74a) begin
    if (!reset_n) begin
      sync1        <= 1'b0;
      locked_s     <= 1'b0;
      cur          <= S_ASSERT;
      cnt          <= '0;
      pll_rst      <= 1'b1;
      core_reset_n <= 1'b0;
      pll_ready    <= 1'b0;
      lock_lost    <= 1'b0;
      retry_count  <= 4'd0;
    end else begin
      sync1    <= pll_locked;
      locked_s <= sync1;
      cur      <= nxt;
      // Counter idles in RUN so it can never wrap there.
      if (clr)               cnt <= '0;
      else if (cur != S_RUN) cnt <= cnt + CW'(1);
      pll_rst      <= (nxt == S_ASSERT);
      core_reset_n <= (nxt == S_RUN);
      pll_ready    <= (nxt == S_RUN);
      if (lost_set) lock_lost <= 1'b1;
      if (retry_inc && retry_count != 4'hF) retry_count <= retry_count + 4'd1;
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short pulse/stable/timeout
// parameters; expected values are hand-derived cycle counts.
module tb_pll_reset_sequencer;

  logic       clk_74a = 1'b0;
  logic       reset_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_rst, core_reset_n, pll_ready, lock_lost;
  logic [3:0] retry_count;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  pll_reset_sequencer #(
    .RST_PULSE_CYCLES(4),
    .LOCK_STABLE_CYCLES(8),
    .TIMEOUT_CYCLES(32)
  ) dut (
    .clk_74a(clk_74a),
    .reset_n(reset_n),
    .pll_locked(pll_locked),
    .relock_req(relock_req),
    .pll_rst(pll_rst),
    .core_reset_n(core_reset_n),
    .pll_ready(pll_ready),
    .lock_lost(lock_lost),
    .retry_count(retry_count),
    .state(state)
  );

  always #5 clk_74a = ~clk_74a;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_74a);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [1:0] st, input logic rst,
                          input logic crn, input logic rdy, input logic ll, input logic [3:0] rc);
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".pll_rst"}, 32'(pll_rst), 32'(rst));
    chk({tag, ".core_reset_n"}, 32'(core_reset_n), 32'(crn));
    chk({tag, ".pll_ready"}, 32'(pll_ready), 32'(rdy));
    chk({tag, ".lock_lost"}, 32'(lock_lost), 32'(ll));
    chk({tag, ".retry_count"}, 32'(retry_count), 32'(rc));
  endtask

  initial begin
    // Reset with lock already present
    pll_locked = 1'b1;
    tick(3);
    chk_outs("reset", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);

    // Nominal bring-up
    reset_n = 1'b1;
    tick(3);
    chk_outs("nom_pulse", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    tick(1);
    chk_outs("nom_wait", 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    tick(1);
    chk("nom_stable", 32'(state), 32'd2);
    tick(7);
    chk("nom_stable_last", 32'(state), 32'd2);
    tick(1);
    chk_outs("nom_run", 2'd3, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);

    // Relock from RUN, then relock inside ASSERT extends the pulse
    relock_req = 1'b1;
    tick(1);
    relock_req = 1'b0;
    chk_outs("relock_run", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    tick(2);
    relock_req = 1'b1;
    tick(1);
    relock_req = 1'b0;
    tick(3);
    chk("relock_ext", 32'(state), 32'd0);
    tick(1);
    chk("relock_ext_wait", 32'(state), 32'd1);
    tick(1);
    chk("relock_stable", 32'(state), 32'd2);

    // One-cycle lock glitch at stable count 5
    tick(5);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(1);
    chk("glitch_still_stable", 32'(state), 32'd2);
    tick(1);
    chk("glitch_to_wait", 32'(state), 32'd1);
    tick(1);
    chk("glitch_restable", 32'(state), 32'd2);
    tick(7);
    chk("glitch_not_yet_run", 32'(state), 32'd2);
    tick(1);
    chk_outs("glitch_run", 2'd3, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);

    // Lock loss in RUN
    pll_locked = 1'b0;
    tick(2);
    chk("loss_sync_delay", 32'(state), 32'd3);
    tick(1);
    chk_outs("loss_assert", 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
    pll_locked = 1'b1;
    tick(4);
    chk("loss_wait", 32'(state), 32'd1);
    tick(1);
    chk("loss_stable", 32'(state), 32'd2);
    tick(8);
    chk_outs("loss_rerun", 2'd3, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0);

    // Timeouts: reset clears sticky flags, then lock stays low
    reset_n = 1'b0;
    pll_locked = 1'b0;
    tick(2);
    chk_outs("to_reset", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    reset_n = 1'b1;
    for (int a = 1; a <= 3; a++) begin
      tick(4);
      chk($sformatf("to_wait%0d", a), 32'(state), 32'd1);
      tick(31);
      chk($sformatf("to_wait_last%0d", a), 32'(state), 32'd1);
      tick(1);
      chk_outs($sformatf("to_assert%0d", a), 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'(a));
    end
    // Fourth attempt: lock rises exactly on the timeout cycle
    tick(4);
    chk("tie_wait", 32'(state), 32'd1);
    tick(29);
    pll_locked = 1'b1;
    tick(2);
    chk("tie_pre", 32'(state), 32'd1);
    tick(1);
    chk_outs("tie_stable", 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3);
    tick(8);
    chk_outs("to_run", 2'd3, 1'b0, 1'b1, 1'b1, 1'b0, 4'd3);

    // Relock coincident with lock loss in RUN
    pll_locked = 1'b0;
    tick(2);
    relock_req = 1'b1;
    tick(1);
    relock_req = 1'b0;
    chk_outs("both_assert", 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3);

    // Reset during STABLE
    pll_locked = 1'b1;
    tick(5);
    chk("rst_mid_stable", 32'(state), 32'd2);
    reset_n = 1'b0;
    tick(1);
    chk_outs("rst_mid", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    reset_n = 1'b1;
    tick(3);
    chk("rst_full_pulse", 32'(state), 32'd0);
    tick(1);
    chk("rst_after_pulse", 32'(state), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
